// File: rtl/popcount_argmax_seq.sv
// ---------------------------------------------------------------------------
// popcount_argmax_seq
//   Sequential argmax-of-popcount engine. A request carries InCnt packed words.
//   It is captured in one cycle. One shared count_ones instance then walks the
//   words, one per cycle. The engine reports the index and ones-count of the
//   word with the most set bits. Ties go to the lowest index.
//
//   Ports
//     clk_i        clock, all state on rising edge
//     rst_i        asynchronous reset, active-high
//     req_valid_i  request word vector valid
//     req_ready_o  engine can accept a request (IDLE only)
//     req_data_i   word k = req_data_i[k*InWdt +: InWdt]
//     res_valid_o  result valid (DONE only)
//     res_ready_i  consumer accepts result
//     res_idx_o    index of the word with the highest popcount
//     res_cnt_o    popcount of that word
//     busy_o       high while scanning or holding a result
// ---------------------------------------------------------------------------

// Combinational ones-counter, instantiated once and shared across words.
module count_ones #(
    parameter int InWdt  = 8,
    parameter int OutWdt = $clog2(InWdt + 1)
) (
    input  logic [InWdt-1:0]  word_i,
    output logic [OutWdt-1:0] cnt_o
);
    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < InWdt; i++) begin
            cnt_o = cnt_o + OutWdt'(word_i[i]);
        end
    end
endmodule

module popcount_argmax_seq #(
    parameter int InCnt  = 4,
    parameter int InWdt  = 8,
    parameter int CntWdt = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [InCnt*InWdt-1:0]    req_data_i,
    output logic                      res_valid_o,
    input  logic                      res_ready_i,
    output logic [$clog2(InCnt)-1:0]  res_idx_o,
    output logic [CntWdt-1:0]         res_cnt_o,
    output logic                      busy_o
);
    localparam int IdxWdt = $clog2(InCnt);
    localparam int PcWdt  = $clog2(InWdt + 1);
    localparam logic [IdxWdt-1:0] LastPtr = IdxWdt'(InCnt - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [InCnt*InWdt-1:0]   data_q, data_d;
    logic [IdxWdt-1:0]        ptr_q, ptr_d;
    logic [CntWdt-1:0]        max_q, max_d;
    logic [IdxWdt-1:0]        idx_q, idx_d;
    logic [IdxWdt-1:0]        res_idx_q, res_idx_d;
    logic [CntWdt-1:0]        res_cnt_q, res_cnt_d;

    // Word view of the captured request, selected by the scan pointer.
    logic [InWdt-1:0] words [InCnt];

    for (genvar gi = 0; gi < InCnt; gi++) begin : g_words
        assign words[gi] = data_q[gi*InWdt +: InWdt];
    end

    logic [InWdt-1:0]  cur_word;
    logic [PcWdt-1:0]  cur_pc;
    logic [CntWdt-1:0] cur_cnt;
    logic              is_greater;

    assign cur_word = words[ptr_q];

    count_ones #(
        .InWdt  (InWdt),
        .OutWdt (PcWdt)
    ) u_count_ones (
        .word_i (cur_word),
        .cnt_o  (cur_pc)
    );

    assign cur_cnt    = CntWdt'(cur_pc);
    // Strict compare: an equal count never displaces an earlier index.
    assign is_greater = (cur_cnt > max_q);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            data_q    <= '0;
            ptr_q     <= '0;
            max_q     <= '0;
            idx_q     <= '0;
            res_idx_q <= '0;
            res_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            ptr_q     <= ptr_d;
            max_q     <= max_d;
            idx_q     <= idx_d;
            res_idx_q <= res_idx_d;
            res_cnt_q <= res_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        ptr_d     = ptr_q;
        max_d     = max_q;
        idx_d     = idx_q;
        res_idx_d = res_idx_q;
        res_cnt_d = res_cnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    data_d  = req_data_i;
                    ptr_d   = '0;
                    max_d   = '0;
                    idx_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (is_greater) begin
                    max_d = cur_cnt;
                    idx_d = ptr_q;
                end
                if (ptr_q == LastPtr) begin
                    // The last compare folds straight into the result registers.
                    res_idx_d = is_greater ? ptr_q   : idx_q;
                    res_cnt_d = is_greater ? cur_cnt : max_q;
                    state_d   = DONE;
                end else begin
                    ptr_d = ptr_q + IdxWdt'(1);
                end
            end
            DONE: begin
                if (res_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // All outputs are decoded from registers only.
    assign req_ready_o = (state_q == IDLE);
    assign res_valid_o = (state_q == DONE);
    assign busy_o      = (state_q == SCAN) || (state_q == DONE);
    assign res_idx_o   = res_idx_q;
    assign res_cnt_o   = res_cnt_q;
endmodule

// File: tb/tb_popcount_argmax_seq.sv
module tb_popcount_argmax_seq;
    localparam int InCnt  = 4;
    localparam int InWdt  = 8;
    localparam int CntWdt = 16;
    localparam int IdxWdt = 2;
    localparam int ResW   = IdxWdt + CntWdt;

    logic                   clk_i = 1'b0;
    logic                   rst_i;
    logic                   req_valid_i;
    logic                   req_ready_o;
    logic [InCnt*InWdt-1:0] req_data_i;
    logic                   res_valid_o;
    logic                   res_ready_i;
    logic [IdxWdt-1:0]      res_idx_o;
    logic [CntWdt-1:0]      res_cnt_o;
    logic                   busy_o;

    popcount_argmax_seq #(
        .InCnt  (InCnt),
        .InWdt  (InWdt),
        .CntWdt (CntWdt)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_data_i  (req_data_i),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready_i),
        .res_idx_o   (res_idx_o),
        .res_cnt_o   (res_cnt_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;
    int acc_cnt = 0;
    int hs_cnt = 0;
    logic [ResW-1:0] exp_q [$];

    always @(posedge clk_i) begin
        if (!rst_i && res_valid_o && res_ready_i) hs_cnt <= hs_cnt + 1;
    end

    function automatic logic [31:0] pack(input logic [7:0] w0, input logic [7:0] w1,
                                         input logic [7:0] w2, input logic [7:0] w3);
        return {w3, w2, w1, w0};
    endfunction

    function automatic logic [ResW-1:0] mk(input int idx, input int cnt);
        return {IdxWdt'(idx), CntWdt'(cnt)};
    endfunction

    // Reference: plain $countones with first-maximum selection.
    function automatic logic [ResW-1:0] ref_model(input logic [31:0] d);
        int best;
        int bi;
        int c;
        logic [7:0] w;
        best = 0;
        bi = 0;
        for (int k = 0; k < InCnt; k++) begin
            w = d[k*InWdt +: InWdt];
            c = $countones(w);
            if (c > best) begin
                best = c;
                bi = k;
            end
        end
        return mk(bi, best);
    endfunction

    // Called on a negedge; returns on the negedge after the accepting edge.
    task automatic send_req(input logic [31:0] d, input logic [ResW-1:0] e,
                            input bit push, output bit ok);
        int t;
        t = 0;
        while (!req_ready_o && t < 50) begin
            @(negedge clk_i);
            t++;
        end
        if (!req_ready_o) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_req_ready: req_ready_o=%0b required 1", req_ready_o);
            ok = 1'b0;
            return;
        end
        req_valid_i = 1'b1;
        req_data_i  = d;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        req_data_i  = ~d;
        if (push) begin
            exp_q.push_back(e);
            acc_cnt++;
        end
        ok = 1'b1;
    endtask

    task automatic wait_res(output bit got, output int lat);
        lat = 0;
        while (!res_valid_o && lat < 40) begin
            @(negedge clk_i);
            lat++;
        end
        got = res_valid_o;
    endtask

    task automatic ack_res();
        res_ready_i = 1'b1;
        @(negedge clk_i);
        res_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk_i);
        n_cmp++;
        if (req_ready_o !== 1'b1 || res_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: ready=%0b valid=%0b busy=%0b required 1 0 0",
                     req_ready_o, res_valid_o, busy_o);
        end
        n_cmp++;
        if (res_idx_o !== '0 || res_cnt_o !== '0) begin
            n_err++;
            $display("FAIL reset_result: idx=%0d cnt=%0d required 0 0", res_idx_o, res_cnt_o);
        end
        rst_i = 1'b0;
        @(negedge clk_i);
        n_cmp++;
        if (req_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_idle: ready=%0b busy=%0b required 1 0", req_ready_o, busy_o);
        end
    endtask

    task automatic test_vectors();
        logic [31:0]     vec [4];
        logic [ResW-1:0] exv [4];
        logic [ResW-1:0] e;
        bit ok;
        bit got;
        int lat;
        vec[0] = pack(8'hAA, 8'h0F, 8'hFF, 8'h00); exv[0] = mk(2, 8);
        vec[1] = pack(8'h55, 8'hFF, 8'hFE, 8'h40); exv[1] = mk(1, 8);
        vec[2] = pack(8'h0F, 8'hF0, 8'h33, 8'h00); exv[2] = mk(0, 4);
        vec[3] = pack(8'h00, 8'h00, 8'h00, 8'h00); exv[3] = mk(0, 0);
        for (int i = 0; i < 4; i++) begin
            send_req(vec[i], exv[i], 1'b1, ok);
            if (!ok) continue;
            n_cmp++;
            if (busy_o !== 1'b1 || req_ready_o !== 1'b0) begin
                n_err++;
                $display("FAIL vec%0d_scan_flags: busy=%0b ready=%0b required 1 0", i, busy_o, req_ready_o);
            end
            wait_res(got, lat);
            e = exp_q.pop_front();
            n_cmp++;
            if (!got) begin
                n_err++;
                $display("FAIL vec%0d_timeout: res_valid_o=0 required 1", i);
                continue;
            end
            n_cmp++;
            if (lat !== InCnt) begin
                n_err++;
                $display("FAIL vec%0d_latency: got %0d cycles required %0d", i, lat, InCnt);
            end
            n_cmp++;
            if ({res_idx_o, res_cnt_o} !== e) begin
                n_err++;
                $display("FAIL vec%0d_result: got idx=%0d cnt=%0d required idx=%0d cnt=%0d",
                         i, res_idx_o, res_cnt_o, e[ResW-1 -: IdxWdt], e[CntWdt-1:0]);
            end
            ack_res();
            n_cmp++;
            if (res_valid_o !== 1'b0 || req_ready_o !== 1'b1 || busy_o !== 1'b0) begin
                n_err++;
                $display("FAIL vec%0d_after_ack: valid=%0b ready=%0b busy=%0b required 0 1 0",
                         i, res_valid_o, req_ready_o, busy_o);
            end
        end
    endtask

    task automatic test_stall();
        logic [ResW-1:0] e;
        bit ok;
        bit got;
        bit bad;
        int lat;
        send_req(pack(8'hAA, 8'h0F, 8'hFF, 8'h00), mk(2, 8), 1'b1, ok);
        if (!ok) return;
        wait_res(got, lat);
        e = exp_q.pop_front();
        n_cmp++;
        if (!got) begin
            n_err++;
            $display("FAIL stall_timeout: res_valid_o=0 required 1");
            return;
        end
        bad = 1'b0;
        for (int j = 0; j < 10; j++) begin
            if (res_valid_o !== 1'b1 || req_ready_o !== 1'b0 || {res_idx_o, res_cnt_o} !== e) bad = 1'b1;
            if (j == 3) begin
                req_valid_i = 1'b1;
                req_data_i  = pack(8'h00, 8'h00, 8'h00, 8'h01);
            end else begin
                req_valid_i = 1'b0;
            end
            @(negedge clk_i);
        end
        req_valid_i = 1'b0;
        n_cmp++;
        if (bad) begin
            n_err++;
            $display("FAIL stall_hold: result/handshake flags changed while res_ready_i=0");
        end
        n_cmp++;
        if ({res_idx_o, res_cnt_o} !== e) begin
            n_err++;
            $display("FAIL stall_result: got idx=%0d cnt=%0d required idx=2 cnt=8", res_idx_o, res_cnt_o);
        end
        ack_res();
        n_cmp++;
        if (req_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL stall_ignored_req: ready=%0b busy=%0b required 1 0", req_ready_o, busy_o);
        end
        send_req(pack(8'h55, 8'hFF, 8'hFE, 8'h40), mk(1, 8), 1'b1, ok);
        if (!ok) return;
        wait_res(got, lat);
        e = exp_q.pop_front();
        n_cmp++;
        if (!got || {res_idx_o, res_cnt_o} !== e) begin
            n_err++;
            $display("FAIL stall_second_req: valid=%0b idx=%0d cnt=%0d required 1 idx=1 cnt=8",
                     res_valid_o, res_idx_o, res_cnt_o);
        end
        if (got) ack_res();
    endtask

    task automatic test_reset_mid_scan();
        logic [ResW-1:0] e;
        bit ok;
        bit got;
        bit seen;
        int lat;
        int hs0;
        send_req(pack(8'hFF, 8'hFF, 8'hFF, 8'hFF), mk(0, 8), 1'b0, ok);
        if (!ok) return;
        @(posedge clk_i);
        #2;
        rst_i = 1'b1;
        #1;
        n_cmp++;
        if (req_ready_o !== 1'b1 || res_valid_o !== 1'b0 || busy_o !== 1'b0 ||
            res_idx_o !== '0 || res_cnt_o !== '0) begin
            n_err++;
            $display("FAIL midscan_reset: ready=%0b valid=%0b busy=%0b idx=%0d cnt=%0d required 1 0 0 0 0",
                     req_ready_o, res_valid_o, busy_o, res_idx_o, res_cnt_o);
        end
        hs0 = hs_cnt;
        @(negedge clk_i);
        rst_i = 1'b0;
        seen = 1'b0;
        for (int j = 0; j < 8; j++) begin
            if (res_valid_o !== 1'b0 || busy_o !== 1'b0) seen = 1'b1;
            @(negedge clk_i);
        end
        n_cmp++;
        if (seen || hs_cnt != hs0) begin
            n_err++;
            $display("FAIL midscan_no_result: aborted request produced activity (valid/busy seen=%0b)", seen);
        end
        send_req(pack(8'h00, 8'h01, 8'h03, 8'h07), mk(3, 3), 1'b1, ok);
        if (!ok) return;
        wait_res(got, lat);
        e = exp_q.pop_front();
        n_cmp++;
        if (!got || {res_idx_o, res_cnt_o} !== e) begin
            n_err++;
            $display("FAIL midscan_after: valid=%0b idx=%0d cnt=%0d required 1 idx=3 cnt=3",
                     res_valid_o, res_idx_o, res_cnt_o);
        end
        if (got) ack_res();
    endtask

    task automatic test_back_to_back();
        logic [31:0]     d;
        logic [ResW-1:0] e;
        bit ok;
        bit got;
        bit bad;
        int lat;
        int stall;
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < InCnt; k++) begin
                d[k*InWdt +: InWdt] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            end
            send_req(d, ref_model(d), 1'b1, ok);
            if (!ok) continue;
            wait_res(got, lat);
            e = exp_q.pop_front();
            n_cmp++;
            if (!got) begin
                n_err++;
                $display("FAIL b2b%0d_timeout: res_valid_o=0 required 1", i);
                continue;
            end
            stall = $urandom_range(0, 3);
            bad = 1'b0;
            for (int j = 0; j < stall; j++) begin
                @(negedge clk_i);
                if (res_valid_o !== 1'b1 || {res_idx_o, res_cnt_o} !== e) bad = 1'b1;
            end
            n_cmp++;
            if (bad || {res_idx_o, res_cnt_o} !== e) begin
                n_err++;
                $display("FAIL b2b%0d_result: data=%h got idx=%0d cnt=%0d required idx=%0d cnt=%0d",
                         i, d, res_idx_o, res_cnt_o, e[ResW-1 -: IdxWdt], e[CntWdt-1:0]);
            end
            ack_res();
        end
        n_cmp++;
        if (hs_cnt != acc_cnt) begin
            n_err++;
            $display("FAIL handshake_count: got %0d required %0d", hs_cnt, acc_cnt);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d left required 0", exp_q.size());
        end
    endtask

    initial begin
        rst_i       = 1'b1;
        req_valid_i = 1'b0;
        req_data_i  = '0;
        res_ready_i = 1'b0;
        test_reset();
        test_vectors();
        test_stall();
        test_reset_mid_scan();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
